text_line_renderer: RTL

- Upstream sequencer for character_renderer; turns a string held in a small character RAM into a series of glyph draws.
- For each character it reads the code, computes the glyph origin, and raises the renderer enable until the renderer reports finished.
- It advances a text cursor, handles space/newline/auto-wrap, and clips at the bottom of the screen.
- Sits between the page/layout controller (start/done) and character_renderer.

---
 rtl/text_line_renderer_if.sv | 43 ++++
 rtl/text_line_renderer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/text_line_renderer_if.sv
// Signal bundle between the page/layout controller, the character RAM and
// character_renderer, as seen by text_line_renderer.
interface text_line_renderer_if #(
    parameter int X_W    = 8,
    parameter int Y_W    = 7,
    parameter int CHAR_W = 8,
    parameter int SIZE_W = 4,
    parameter int LEN_W  = 6
);
    logic              start;
    logic [LEN_W-1:0]  str_len;
    logic [X_W-1:0]    origin_x;
    logic [Y_W-1:0]    origin_y;
    logic [SIZE_W-1:0] size;

    logic [LEN_W-1:0]  mem_addr;
    logic [CHAR_W-1:0] mem_data;

    logic [CHAR_W-1:0] cr_char;
    logic [X_W-1:0]    cr_origin_x;
    logic [Y_W-1:0]    cr_origin_y;
    logic [SIZE_W-1:0] cr_size;
    logic              cr_enable;
    logic              cr_finished;

    logic              busy;
    logic              done;
    logic              clipped;

    // Sequencer view
    modport master (
        input  start, str_len, origin_x, origin_y, size, mem_data, cr_finished,
        output mem_addr, cr_char, cr_origin_x, cr_origin_y, cr_size, cr_enable,
               busy, done, clipped
    );

    // Environment view: controller, RAM and renderer
    modport slave (
        output start, str_len, origin_x, origin_y, size, mem_data, cr_finished,
        input  mem_addr, cr_char, cr_origin_x, cr_origin_y, cr_size, cr_enable,
               busy, done, clipped
    );
endinterface

// File: rtl/text_line_renderer.sv
// Walks a string in the character RAM and issues one character_renderer draw per glyph.
// Optional: define TEXT_LINE_RENDERER_WRAP_EN to wrap right-edge overflow onto the next line.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start; inputs captured when it arrives
// FETCH    | mem_addr = index presented to the character RAM
// LOAD     | RAM data registered into cr_char
// DECODE   | newline / bottom clip / right edge / space / draw decision
// DRAW     | cr_enable held high until cr_finished
// RELEASE  | one forced low cycle of cr_enable between glyphs
// NEXT     | index advance, end-of-string test
// DONE     | done pulse, busy drops
module text_line_renderer #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int CHAR_W   = 8,
    parameter int SIZE_W   = 4,
    parameter int LEN_W    = 6,
    parameter int FONT_W   = 5,
    parameter int FONT_H   = 7,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic                  clock,
    input  logic                  resetn,
    text_line_renderer_if.master  bus
);
    localparam int XS = X_W + 1;
    localparam int YC = Y_W + 1;
    // Extra bit on y sums so a saturated cursor plus a glyph height cannot wrap
    localparam int YS = Y_W + 2;

    localparam logic [CHAR_W-1:0] CH_NL    = CHAR_W'(8'h0A);
    localparam logic [CHAR_W-1:0] CH_SPACE = CHAR_W'(8'h20);
    localparam logic [YS-1:0]     Y_MAX    = YS'({YC{1'b1}});

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_DECODE,
        S_DRAW,
        S_RELEASE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;

    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  index_q;
    logic [X_W-1:0]    ox_q;
    logic [SIZE_W-1:0] size_q;
    logic [XS-1:0]     cur_x_q;
    logic [YC-1:0]     cur_y_q;
    logic [CHAR_W-1:0] char_q;
    logic [X_W-1:0]    org_x_q;
    logic [Y_W-1:0]    org_y_q;
    logic [SIZE_W-1:0] cr_size_q;
    logic              enable_q;
    logic              busy_q;
    logic              done_q;
    logic              clipped_q;

    logic [XS-1:0]     glyph_w, adv_x;
    logic [YS-1:0]     glyph_h, adv_y, y_sum;
    logic [YC-1:0]     y_step;
    logic              is_nl, is_space, right_hit, bottom_hit, last_char;

    assign glyph_w    = XS'(size_q) * XS'(FONT_W);
    assign adv_x      = XS'(size_q) * XS'(FONT_W + 1);
    assign glyph_h    = YS'(size_q) * YS'(FONT_H);
    assign adv_y      = YS'(size_q) * YS'(FONT_H + 1);

    assign is_nl      = (char_q == CH_NL);
    assign is_space   = (char_q == CH_SPACE);
    assign right_hit  = (cur_x_q + glyph_w) > XS'(SCREEN_W);
    assign bottom_hit = (YS'(cur_y_q) + glyph_h) > YS'(SCREEN_H);
    assign last_char  = (index_q == (len_q - LEN_W'(1)));

    // Line feed saturates so repeated newlines still land below the screen
    assign y_sum      = YS'(cur_y_q) + adv_y;
    assign y_step     = (y_sum > Y_MAX) ? {YC{1'b1}} : y_sum[YC-1:0];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = (bus.str_len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH:   state_d = S_LOAD;
            S_LOAD:    state_d = S_DECODE;
            S_DECODE: begin
                if (is_nl) begin
                    state_d = S_NEXT;
                end else if (bottom_hit) begin
                    state_d = S_DONE;
                end else if (right_hit) begin
`ifdef TEXT_LINE_RENDERER_WRAP_EN
                    state_d = S_DECODE;
`else
                    state_d = S_NEXT;
`endif
                end else if (is_space) begin
                    state_d = S_NEXT;
                end else begin
                    state_d = S_DRAW;
                end
            end
            S_DRAW: begin
                if (bus.cr_finished) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: state_d = S_NEXT;
            S_NEXT:    state_d = last_char ? S_DONE : S_FETCH;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            len_q     <= '0;
            index_q   <= '0;
            ox_q      <= '0;
            size_q    <= '0;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            char_q    <= '0;
            org_x_q   <= '0;
            org_y_q   <= '0;
            cr_size_q <= '0;
            enable_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            clipped_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        len_q     <= bus.str_len;
                        ox_q      <= bus.origin_x;
                        size_q    <= (bus.size == '0) ? SIZE_W'(1) : bus.size;
                        cur_x_q   <= XS'(bus.origin_x);
                        cur_y_q   <= YC'(bus.origin_y);
                        index_q   <= '0;
                        clipped_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                S_LOAD: char_q <= bus.mem_data;
                S_DECODE: begin
                    if (is_nl) begin
                        cur_x_q <= XS'(ox_q);
                        cur_y_q <= y_step;
                    end else if (bottom_hit) begin
                        clipped_q <= 1'b1;
                    end else if (right_hit) begin
`ifdef TEXT_LINE_RENDERER_WRAP_EN
                        cur_x_q <= XS'(ox_q);
                        cur_y_q <= y_step;
`endif
                    end else if (is_space) begin
                        cur_x_q <= cur_x_q + adv_x;
                    end else begin
                        // Both edge tests passed, so the cursor fits the output widths
                        org_x_q   <= cur_x_q[X_W-1:0];
                        org_y_q   <= cur_y_q[Y_W-1:0];
                        cr_size_q <= size_q;
                        enable_q  <= 1'b1;
                    end
                end
                S_DRAW: begin
                    if (bus.cr_finished) begin
                        enable_q <= 1'b0;
                        cur_x_q  <= cur_x_q + adv_x;
                    end
                end
                S_NEXT: index_q <= index_q + LEN_W'(1);
                S_DONE: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_addr    = index_q;
    assign bus.cr_char     = char_q;
    assign bus.cr_origin_x = org_x_q;
    assign bus.cr_origin_y = org_y_q;
    assign bus.cr_size     = cr_size_q;
    assign bus.cr_enable   = enable_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.clipped     = clipped_q;
endmodule
